// File: rtl/mem_stage_pkg.sv
// mem_stage shared definitions: widths, op/exception codes, bus FSM states
// and the MEM pipeline register layout.
package mem_stage_pkg;

  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;

  typedef enum logic [1:0] {
    MEM_OP_NOP = 2'd0,
    MEM_OP_LDW = 2'd1,
    MEM_OP_STW = 2'd2
  } mem_op_e;

  localparam logic [1:0] CTRL_OP_NOP        = 2'd0;
  localparam logic [2:0] ISA_EXP_NO_EXP     = 3'h0;
  localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'h4;

  // Bus slave index decoded from the top three byte-address bits
  localparam logic [2:0] BUS_SLAVE_SPM = 3'd3;

  typedef enum logic [1:0] {
    BUS_IDLE   = 2'd0,
    BUS_REQ    = 2'd1,
    BUS_ACCESS = 2'd2,
    BUS_STALL  = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic [WORD_ADDR_W-1:0] pc;
    logic                   en_;
    logic                   br_flag;
    logic                   gpr_we_;
    logic [1:0]             ctrl_op;
    logic [4:0]             dst_addr;
    logic [2:0]             exp_code;
    logic [WORD_DATA_W-1:0] out;
  } mem_reg_t;

  localparam mem_reg_t MEM_BUBBLE = '{
    pc:       '0,
    en_:      1'b1,
    br_flag:  1'b0,
    gpr_we_:  1'b1,
    ctrl_op:  CTRL_OP_NOP,
    dst_addr: '0,
    exp_code: ISA_EXP_NO_EXP,
    out:      '0
  };

  function automatic logic is_spm_addr(input logic [WORD_DATA_W-1:0] byte_addr);
    return byte_addr[WORD_DATA_W-1 -: 3] == BUS_SLAVE_SPM;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Scratchpad and shared-bus signals of the MEM stage.
// master = MEM stage side, slave = SPM / bus side.
interface mem_stage_if;

  logic                                 spm_as_;
  logic                                 spm_rw;
  logic [mem_stage_pkg::WORD_ADDR_W-1:0] spm_addr;
  logic [mem_stage_pkg::WORD_DATA_W-1:0] spm_wr_data;
  logic [mem_stage_pkg::WORD_DATA_W-1:0] spm_rd_data;

  logic                                 bus_req_;
  logic                                 bus_grnt_;
  logic                                 bus_as_;
  logic                                 bus_rw;
  logic                                 bus_rdy_;
  logic [mem_stage_pkg::WORD_ADDR_W-1:0] bus_addr;
  logic [mem_stage_pkg::WORD_DATA_W-1:0] bus_wr_data;
  logic [mem_stage_pkg::WORD_DATA_W-1:0] bus_rd_data;

  modport master (
    output spm_as_, spm_rw, spm_addr, spm_wr_data,
    input  spm_rd_data,
    output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    input  bus_grnt_, bus_rdy_, bus_rd_data
  );

  modport slave (
    input  spm_as_, spm_rw, spm_addr, spm_wr_data,
    output spm_rd_data,
    input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
    output bus_grnt_, bus_rdy_, bus_rd_data
  );

endinterface

// File: rtl/mem_bus_if.sv
// SPM / shared-bus access engine: request-grant-ready FSM and read buffer.
module mem_bus_if
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   req,
  input  logic                   rw,
  input  logic                   to_spm,
  input  logic [WORD_ADDR_W-1:0] addr,
  input  logic [WORD_DATA_W-1:0] wr_data,
  output logic [WORD_DATA_W-1:0] rd_data,
  output logic                   busy,
  mem_stage_if.master            mif
);

  bus_state_e             state_q, state_d;
  logic                   bus_as_q, bus_as_d;
  logic                   bus_rw_q, bus_rw_d;
  logic [WORD_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [WORD_DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic                   bus_req_n;
  logic                   spm_as_n;

  // FSM next state; address/data captured when a bus access starts
  always_comb begin
    state_d       = state_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    unique case (state_q)
      BUS_IDLE: begin
        if (req && !to_spm) begin
          bus_addr_d    = addr;
          bus_wr_data_d = wr_data;
          bus_rw_d      = rw;
          if (!mif.bus_grnt_) begin
            bus_as_d = 1'b0;
            state_d  = BUS_ACCESS;
          end else begin
            state_d  = BUS_REQ;
          end
        end
      end
      BUS_REQ: begin
        if (!mif.bus_grnt_) begin
          bus_as_d = 1'b0;
          state_d  = BUS_ACCESS;
        end
      end
      BUS_ACCESS: begin
        if (!mif.bus_rdy_) begin
          bus_as_d = 1'b1;
          rd_buf_d = mif.bus_rd_data;
          state_d  = stall ? BUS_STALL : BUS_IDLE;
        end
      end
      BUS_STALL: begin
        if (!stall) state_d = BUS_IDLE;
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  // Request/strobe, busy and load-data select; bus_req_ and spm_as_ must
  // respond in the same cycle EX presents the op, so they stay combinational
  always_comb begin
    bus_req_n = 1'b1;
    spm_as_n  = 1'b1;
    busy      = 1'b0;
    rd_data   = mif.spm_rd_data;
    unique case (state_q)
      BUS_IDLE: begin
        if (req) begin
          if (to_spm) begin
            spm_as_n  = 1'b0;
          end else begin
            bus_req_n = 1'b0;
            busy      = 1'b1;
          end
        end
      end
      BUS_REQ: begin
        bus_req_n = 1'b0;
        busy      = 1'b1;
      end
      BUS_ACCESS: begin
        bus_req_n = 1'b0;
        busy      = mif.bus_rdy_;
        rd_data   = mif.bus_rd_data;
      end
      BUS_STALL: begin
        bus_req_n = 1'b0;
        rd_data   = rd_buf_q;
      end
      default: ;
    endcase
  end

  // FSM state and registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BUS_IDLE;
      bus_as_q      <= 1'b1;
      bus_rw_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
    end else begin
      state_q       <= state_d;
      bus_as_q      <= bus_as_d;
      bus_rw_q      <= bus_rw_d;
      bus_addr_q    <= bus_addr_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
    end
  end

  assign mif.spm_as_     = spm_as_n;
  assign mif.spm_rw      = rw;
  assign mif.spm_addr    = addr;
  assign mif.spm_wr_data = wr_data;
  assign mif.bus_req_    = bus_req_n;
  assign mif.bus_as_     = bus_as_q;
  assign mif.bus_rw      = bus_rw_q;
  assign mif.bus_addr    = bus_addr_q;
  assign mif.bus_wr_data = bus_wr_data_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: load/store decode, misalign check, MEM pipeline register.
// Optional: define MEM_MISALIGN_CHECK_EN to trap non-word-aligned LDW/STW.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  input  logic                   ex_en_,
  input  logic                   ex_br_flag,
  input  logic                   ex_gpr_we_,
  input  logic [WORD_ADDR_W-1:0] ex_pc,
  input  logic [1:0]             ex_mem_op,
  input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
  input  logic [WORD_DATA_W-1:0] ex_out,
  input  logic [1:0]             ex_ctrl_op,
  input  logic [4:0]             ex_dst_addr,
  input  logic [2:0]             ex_exp_code,
  mem_stage_if.master            mif,
  output logic [WORD_ADDR_W-1:0] mem_pc,
  output logic                   mem_en_,
  output logic                   mem_br_flag,
  output logic                   mem_gpr_we_,
  output logic [1:0]             mem_ctrl_op,
  output logic [4:0]             mem_dst_addr,
  output logic [2:0]             mem_exp_code,
  output logic [WORD_DATA_W-1:0] mem_out
);

  mem_op_e                op;
  logic                   is_mem_op;
  logic                   miss_align;
  logic                   access;
  logic [WORD_DATA_W-1:0] rd_data;
  mem_reg_t               mem_q, mem_d;

  assign op        = mem_op_e'(ex_mem_op);
  assign is_mem_op = (op == MEM_OP_LDW) || (op == MEM_OP_STW);

`ifdef MEM_MISALIGN_CHECK_EN
  assign miss_align = is_mem_op && (ex_out[1:0] != 2'b00);
`else
  logic unused_byte_ofs;
  assign miss_align      = 1'b0;
  assign unused_byte_ofs = ^ex_out[1:0];
`endif

  // Reset also gates the request so no strobe fires while reset is held
  assign access = !reset && !ex_en_ && is_mem_op && (ex_exp_code == ISA_EXP_NO_EXP)
                  && !miss_align && !flush;

  mem_bus_if u_bus (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .req     (access),
    .rw      (op == MEM_OP_LDW),
    .to_spm  (is_spm_addr(ex_out)),
    .addr    (ex_out[WORD_DATA_W-1:2]),
    .wr_data (ex_mem_wr_data),
    .rd_data (rd_data),
    .busy    (busy),
    .mif     (mif)
  );

  // Next MEM pipeline register contents: hold on stall, bubble on flush
  always_comb begin
    mem_d = mem_q;
    if (!stall) begin
      if (flush) begin
        mem_d = MEM_BUBBLE;
      end else begin
        mem_d.pc       = ex_pc;
        mem_d.en_      = ex_en_;
        mem_d.br_flag  = ex_br_flag;
        mem_d.gpr_we_  = ex_gpr_we_;
        mem_d.ctrl_op  = ex_ctrl_op;
        mem_d.dst_addr = ex_dst_addr;
        mem_d.exp_code = ex_exp_code;
        if (miss_align) begin
          mem_d.exp_code = ISA_EXP_MISS_ALIGN;
          mem_d.gpr_we_  = 1'b1;
          mem_d.out      = '0;
        end else begin
          mem_d.out = (op == MEM_OP_LDW) ? rd_data : ex_out;
        end
      end
    end
  end

  // MEM pipeline register
  always_ff @(posedge clk) begin
    if (reset) mem_q <= MEM_BUBBLE;
    else       mem_q <= mem_d;
  end

  assign mem_pc       = mem_q.pc;
  assign mem_en_      = mem_q.en_;
  assign mem_br_flag  = mem_q.br_flag;
  assign mem_gpr_we_  = mem_q.gpr_we_;
  assign mem_ctrl_op  = mem_q.ctrl_op;
  assign mem_dst_addr = mem_q.dst_addr;
  assign mem_exp_code = mem_q.exp_code;
  assign mem_out      = mem_q.out;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ext_stall;
  logic        flush;
  logic        busy;
  logic        ex_en_, ex_br_flag, ex_gpr_we_;
  logic [29:0] ex_pc;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [1:0]  ex_ctrl_op;
  logic [4:0]  ex_dst_addr;
  logic [2:0]  ex_exp_code;
  logic [29:0] mem_pc;
  logic        mem_en_, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  int checks   = 0;
  int failures = 0;

  mem_stage_if mif ();

  mem_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .busy           (busy),
    .ex_en_         (ex_en_),
    .ex_br_flag     (ex_br_flag),
    .ex_gpr_we_     (ex_gpr_we_),
    .ex_pc          (ex_pc),
    .ex_mem_op      (ex_mem_op),
    .ex_mem_wr_data (ex_mem_wr_data),
    .ex_out         (ex_out),
    .ex_ctrl_op     (ex_ctrl_op),
    .ex_dst_addr    (ex_dst_addr),
    .ex_exp_code    (ex_exp_code),
    .mif            (mif),
    .mem_pc         (mem_pc),
    .mem_en_        (mem_en_),
    .mem_br_flag    (mem_br_flag),
    .mem_gpr_we_    (mem_gpr_we_),
    .mem_ctrl_op    (mem_ctrl_op),
    .mem_dst_addr   (mem_dst_addr),
    .mem_exp_code   (mem_exp_code),
    .mem_out        (mem_out)
  );

  always #5 clk = ~clk;

  // Control unit view: the stage stalls itself while busy
  assign stall = busy | ext_stall;

  // Small scratchpad model
  logic [31:0] spm_mem [16];
  always @(posedge clk) begin
    if (!mif.spm_as_ && !mif.spm_rw) spm_mem[mif.spm_addr[3:0]] <= mif.spm_wr_data;
  end
  assign mif.spm_rd_data = spm_mem[mif.spm_addr[3:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    ex_en_ = 1'b1; ex_br_flag = 1'b0; ex_gpr_we_ = 1'b1; ex_pc = '0;
    ex_mem_op = 2'd0; ex_mem_wr_data = '0; ex_out = '0;
    ex_ctrl_op = 2'd0; ex_dst_addr = '0; ex_exp_code = 3'd0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] dst,
                        input logic [29:0] pc);
    ex_en_ = 1'b0; ex_br_flag = 1'b0; ex_gpr_we_ = (op == 2'd1) ? 1'b0 : 1'b1;
    ex_pc = pc; ex_mem_op = op; ex_mem_wr_data = wd; ex_out = addr;
    ex_ctrl_op = 2'd0; ex_dst_addr = dst; ex_exp_code = 3'd0;
  endtask

  initial begin
    reset = 1'b1; ext_stall = 1'b0; flush = 1'b0;
    set_nop();
    mif.bus_grnt_ = 1'b1; mif.bus_rdy_ = 1'b1; mif.bus_rd_data = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_mem_en_", {31'd0, mem_en_}, 32'd1);
    chk("rst_mem_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("rst_mem_out", mem_out, 32'd0);
    chk("rst_mem_exp", {29'd0, mem_exp_code}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_req_", {31'd0, mif.bus_req_}, 32'd1);
    chk("rst_bus_as_", {31'd0, mif.bus_as_}, 32'd1);
    chk("rst_spm_as_", {31'd0, mif.spm_as_}, 32'd1);
    chk("rst_bus_addr", {2'd0, mif.bus_addr}, 32'd0);

    // SPM store then load to the same word
    set_op(2'd2, 32'h6000_0010, 32'hDEAD_BEEF, 5'd0, 30'h10);
    #1;
    chk("spm_st_as_", {31'd0, mif.spm_as_}, 32'd0);
    chk("spm_st_rw", {31'd0, mif.spm_rw}, 32'd0);
    chk("spm_st_addr", {2'd0, mif.spm_addr}, 32'h1800_0004);
    chk("spm_st_busy", {31'd0, busy}, 32'd0);
    chk("spm_st_bus_req_", {31'd0, mif.bus_req_}, 32'd1);
    tick();
    chk("spm_st_mem_out", mem_out, 32'h6000_0010);
    chk("spm_st_mem_pc", {2'd0, mem_pc}, 32'h10);
    chk("spm_st_mem_en_", {31'd0, mem_en_}, 32'd0);
    set_op(2'd1, 32'h6000_0010, 32'd0, 5'd5, 30'h11);
    #1;
    chk("spm_ld_as_", {31'd0, mif.spm_as_}, 32'd0);
    chk("spm_ld_rw", {31'd0, mif.spm_rw}, 32'd1);
    chk("spm_ld_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("spm_ld_mem_out", mem_out, 32'hDEAD_BEEF);
    chk("spm_ld_gpr_we_", {31'd0, mem_gpr_we_}, 32'd0);
    chk("spm_ld_dst", {27'd0, mem_dst_addr}, 32'd5);

    // Bus load: grant in 3rd cycle, ready in 3rd ACCESS cycle
    set_op(2'd1, 32'h0000_0100, 32'd0, 5'd6, 30'h12);
    mif.bus_rd_data = 32'hCAFE_0001;
    #1;
    chk("bus_c0_busy", {31'd0, busy}, 32'd1);
    chk("bus_c0_req_", {31'd0, mif.bus_req_}, 32'd0);
    chk("bus_c0_as_", {31'd0, mif.bus_as_}, 32'd1);
    tick();
    chk("bus_c1_busy", {31'd0, busy}, 32'd1);
    chk("bus_c1_req_", {31'd0, mif.bus_req_}, 32'd0);
    tick();
    mif.bus_grnt_ = 1'b0;
    #1;
    chk("bus_c2_busy", {31'd0, busy}, 32'd1);
    tick();
    mif.bus_grnt_ = 1'b1;
    #1;
    chk("bus_c3_as_", {31'd0, mif.bus_as_}, 32'd0);
    chk("bus_c3_addr", {2'd0, mif.bus_addr}, 32'h40);
    chk("bus_c3_rw", {31'd0, mif.bus_rw}, 32'd1);
    chk("bus_c3_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("bus_c4_busy", {31'd0, busy}, 32'd1);
    chk("bus_c4_hold", mem_out, 32'hDEAD_BEEF);
    tick();
    mif.bus_rdy_ = 1'b0;
    #1;
    chk("bus_c5_busy", {31'd0, busy}, 32'd0);
    tick();
    mif.bus_rdy_ = 1'b1;
    set_nop();
    chk("bus_ld_mem_out", mem_out, 32'hCAFE_0001);
    chk("bus_ld_dst", {27'd0, mem_dst_addr}, 32'd6);
    #1;
    chk("bus_idle_req_", {31'd0, mif.bus_req_}, 32'd1);
    chk("bus_idle_as_", {31'd0, mif.bus_as_}, 32'd1);

    // Ready arrives while externally stalled: data parks in rd_buf
    set_op(2'd1, 32'h0000_0200, 32'd0, 5'd8, 30'h13);
    mif.bus_grnt_ = 1'b0;
    mif.bus_rd_data = 32'h1234_5678;
    tick();
    mif.bus_grnt_ = 1'b1;
    ext_stall = 1'b1;
    mif.bus_rdy_ = 1'b0;
    #1;
    chk("stl_rdy_busy", {31'd0, busy}, 32'd0);
    tick();
    mif.bus_rdy_ = 1'b1;
    mif.bus_rd_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stl_hold_out", mem_out, 32'hCAFE_0001);
      chk("stl_busy", {31'd0, busy}, 32'd0);
      chk("stl_req_", {31'd0, mif.bus_req_}, 32'd0);
      tick();
    end
    ext_stall = 1'b0;
    tick();
    set_nop();
    chk("stl_rd_buf_out", mem_out, 32'h1234_5678);
    #1;
    chk("stl_idle_req_", {31'd0, mif.bus_req_}, 32'd1);

    // Misaligned load
    set_op(2'd1, 32'h0000_0102, 32'd0, 5'd7, 30'h14);
    mif.bus_grnt_ = 1'b0;
    #1;
`ifdef MEM_MISALIGN_CHECK_EN
    chk("mis_bus_req_", {31'd0, mif.bus_req_}, 32'd1);
    chk("mis_spm_as_", {31'd0, mif.spm_as_}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    tick();
    mif.bus_grnt_ = 1'b1;
    set_nop();
    chk("mis_exp", {29'd0, mem_exp_code}, 32'h4);
    chk("mis_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("mis_out", mem_out, 32'd0);
    chk("mis_en_", {31'd0, mem_en_}, 32'd0);
`else
    chk("mis_bus_req_", {31'd0, mif.bus_req_}, 32'd0);
    chk("mis_spm_as_", {31'd0, mif.spm_as_}, 32'd1);
    tick();
    mif.bus_grnt_ = 1'b1;
    mif.bus_rdy_ = 1'b0;
    mif.bus_rd_data = 32'h0BAD_F00D;
    #1;
    chk("mis_bus_addr", {2'd0, mif.bus_addr}, 32'h40);
    tick();
    mif.bus_rdy_ = 1'b1;
    set_nop();
    chk("mis_out", mem_out, 32'h0BAD_F00D);
    chk("mis_exp", {29'd0, mem_exp_code}, 32'h0);
    chk("mis_gpr_we_", {31'd0, mem_gpr_we_}, 32'd0);
`endif

    // Flush during ACCESS: transfer completes, bubble registered
    set_op(2'd1, 32'h0000_0300, 32'd0, 5'd9, 30'h15);
    mif.bus_grnt_ = 1'b0;
    tick();
    mif.bus_grnt_ = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_busy", {31'd0, busy}, 32'd1);
    chk("fl_as_", {31'd0, mif.bus_as_}, 32'd0);
    tick();
    mif.bus_rdy_ = 1'b0;
    mif.bus_rd_data = 32'h5555_AAAA;
    #1;
    chk("fl_done_busy", {31'd0, busy}, 32'd0);
    tick();
    mif.bus_rdy_ = 1'b1;
    flush = 1'b0;
    set_nop();
    chk("fl_mem_en_", {31'd0, mem_en_}, 32'd1);
    chk("fl_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);
    chk("fl_out", mem_out, 32'd0);
    chk("fl_dst", {27'd0, mem_dst_addr}, 32'd0);
    #1;
    chk("fl_as_rel", {31'd0, mif.bus_as_}, 32'd1);
    chk("fl_req_rel", {31'd0, mif.bus_req_}, 32'd1);

    // Reset pulse while in REQ
    set_op(2'd2, 32'h6000_0020, 32'h11, 5'd0, 30'h77);
    tick();
    chk("rq_pre_en_", {31'd0, mem_en_}, 32'd0);
    set_op(2'd1, 32'h0000_0400, 32'd0, 5'd3, 30'h78);
    tick();
    chk("rq_req_", {31'd0, mif.bus_req_}, 32'd0);
    chk("rq_hold_out", mem_out, 32'h6000_0020);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_nop();
    #1;
    chk("rq_rst_req_", {31'd0, mif.bus_req_}, 32'd1);
    chk("rq_rst_as_", {31'd0, mif.bus_as_}, 32'd1);
    chk("rq_rst_busy", {31'd0, busy}, 32'd0);
    chk("rq_rst_en_", {31'd0, mem_en_}, 32'd1);
    chk("rq_rst_out", mem_out, 32'd0);
    chk("rq_rst_pc", {2'd0, mem_pc}, 32'd0);
    chk("rq_rst_gpr_we_", {31'd0, mem_gpr_we_}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
